// File: rtl/vga_timing_fetch.sv
// VGA raster timing generator with linear frame-buffer fetch. The timing flags are delayed
// to match the read latency, so each output pixel carries its own sync and active flags.
module vga_timing_fetch #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   RD_LAT   = 2,
  parameter int   ADDR_W   = 19
) (
  input  logic              i_p_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [11:0]       i_rd_data,
  output logic [11:0]       o_pixel,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_active_area,
  output logic              o_frame_start,
  output logic [9:0]        o_x,
  output logic [9:0]        o_y
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HBITS   = $clog2(H_TOTAL);
  localparam int VBITS   = $clog2(V_TOTAL);
  localparam int CW0     = (HBITS > VBITS) ? HBITS : VBITS;
  localparam int CW      = (CW0 > 10) ? CW0 : 10;

  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_START_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);

  generate
    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
      $error("vga_timing_fetch: RD_LAT=%0d is outside the legal range 1..8", RD_LAT);
    end
    if ((longint'(1) << ADDR_W) < longint'(H_ACTIVE) * longint'(V_ACTIVE)) begin : g_bad_addr_w
      $error("vga_timing_fetch: ADDR_W=%0d cannot address the visible area", ADDR_W);
    end
  endgenerate

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] h;
    logic [9:0] v;
  } timing_t;

  localparam timing_t IDLE = '{act: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0, h: 10'd0, v: 10'd0};

  logic [CW-1:0]     h_reg, h_next;
  logic [CW-1:0]     v_reg, v_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  timing_t           stage0;
  timing_t           pipe_reg [RD_LAT+1];

  // Stage-0 decode; a low enable gates every flag and parks the raster at the origin.
  always_comb begin
    stage0      = IDLE;
    stage0.h    = h_reg[9:0];
    stage0.v    = v_reg[9:0];
    h_next      = '0;
    v_next      = '0;
    addr_next   = '0;
    if (i_en) begin
      stage0.act = (h_reg < H_ACT_C) && (v_reg < V_ACT_C);
      stage0.hs  = (h_reg >= HS_START_C && h_reg < HS_END_C) ? SYNC_POL : ~SYNC_POL;
      stage0.vs  = (v_reg >= VS_START_C && v_reg < VS_END_C) ? SYNC_POL : ~SYNC_POL;
      stage0.fs  = (h_reg == '0) && (v_reg == '0);
      if (h_reg == H_LAST_C) begin
        h_next = '0;
        v_next = (v_reg == V_LAST_C) ? '0 : v_reg + 1'b1;
      end else begin
        h_next = h_reg + 1'b1;
        v_next = v_reg;
      end
      if (h_reg == H_LAST_C && v_reg == V_LAST_C) begin
        addr_next = '0;
      end else if (stage0.act) begin
        addr_next = addr_reg + 1'b1;
      end else begin
        addr_next = addr_reg;
      end
    end
  end

  always_ff @(posedge i_p_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_reg         <= '0;
      v_reg         <= '0;
      addr_reg      <= '0;
      o_rd_en       <= 1'b0;
      o_rd_addr     <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_reg[i] <= IDLE;
      o_pixel       <= 12'h000;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_active_area <= 1'b0;
      o_frame_start <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
    end else begin
      h_reg    <= h_next;
      v_reg    <= v_next;
      addr_reg <= addr_next;
      o_rd_en  <= stage0.act;
      if (stage0.act) o_rd_addr <= addr_reg;
      // RD_LAT+1 stages: the last one lines up with the word returned for the same pixel.
      pipe_reg[0] <= stage0;
      for (int i = 1; i <= RD_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
      o_pixel       <= pipe_reg[RD_LAT].act ? i_rd_data : 12'h000;
      o_hsync       <= pipe_reg[RD_LAT].hs;
      o_vsync       <= pipe_reg[RD_LAT].vs;
      o_active_area <= pipe_reg[RD_LAT].act;
      o_frame_start <= pipe_reg[RD_LAT].fs;
      o_x           <= pipe_reg[RD_LAT].h;
      o_y           <= pipe_reg[RD_LAT].v;
    end
  end

endmodule

// File: tb/tb_vga_timing_fetch.sv
// Bench for vga_timing_fetch: two instances (RD_LAT 2 and 5) on a small raster, a raster
// reference model with frame-buffer models, a directed vector table and enable/reset sequences.
module tb_vga_timing_fetch;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int AW = 5;
  localparam int LAT_A = 2, LAT_B = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];
  logic [11:0]   rd_data [2];
  logic [11:0]   pix     [2];
  logic          hsync   [2];
  logic          vsync   [2];
  logic          act     [2];
  logic          fs      [2];
  logic [9:0]    x       [2];
  logic [9:0]    y       [2];

  vga_timing_fetch #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                     .SYNC_POL(1'b0), .RD_LAT(LAT_A), .ADDR_W(AW)) u_dut_a (
    .i_p_clk(clk), .i_rstn(rstn), .i_en(en),
    .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]),
    .o_pixel(pix[0]), .o_hsync(hsync[0]), .o_vsync(vsync[0]),
    .o_active_area(act[0]), .o_frame_start(fs[0]), .o_x(x[0]), .o_y(y[0]));

  vga_timing_fetch #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                     .SYNC_POL(1'b0), .RD_LAT(LAT_B), .ADDR_W(AW)) u_dut_b (
    .i_p_clk(clk), .i_rstn(rstn), .i_en(en),
    .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
    .o_pixel(pix[1]), .o_hsync(hsync[1]), .o_vsync(vsync[1]),
    .o_active_area(act[1]), .o_frame_start(fs[1]), .o_x(x[1]), .o_y(y[1]));

  typedef struct {
    int act; int hs; int vs; int fs; int h; int v; int addr;
  } s0_t;

  typedef struct {
    int k; int rd_en; int rd_addr; int act; int hs; int vs; int pix; int fs;
  } vec_t;

  s0_t  hist [16];
  int   pos = 0;
  bit   en_prev = 1'b0;
  int   exp_addr = 0;
  bit   mem_en   [2][16];
  int   mem_addr [2][16];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [18];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  // Raster position p (cycles since frame start) mapped to what the pixel should look like.
  function automatic s0_t decode(input int p, input bit e);
    s0_t s;
    s.h    = p % HT;
    s.v    = p / HT;
    s.act  = (e && s.h < HA && s.v < VA) ? 1 : 0;
    s.hs   = (e && s.h >= HA + HFP && s.h < HA + HFP + HS) ? 0 : 1;
    s.vs   = (e && s.v >= VA + VFP && s.v < VA + VFP + VS) ? 0 : 1;
    s.fs   = (e && p == 0) ? 1 : 0;
    s.addr = s.v * HA + s.h;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic rise(input bit e);
    @(posedge clk);
    #1;
    pos = en_prev ? (pos + 1) % FRAME : 0;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    en      = e;
    en_prev = e;
    hist[0] = decode(pos, e);
    if (hist[1].act != 0) exp_addr = hist[1].addr;
  endtask

  task automatic fall();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int  lat;
      s0_t r;
      lat = lat_of(d);
      for (int i = 15; i > 0; i--) begin
        mem_en[d][i]   = mem_en[d][i-1];
        mem_addr[d][i] = mem_addr[d][i-1];
      end
      mem_en[d][0]   = rd_en[d];
      mem_addr[d][0] = 32'(rd_addr[d]);
      rd_data[d]     = mem_en[d][lat] ? 12'(mem_addr[d][lat]) : 12'($urandom);
      r = hist[lat + 2];
      chk($sformatf("rd_en[%0d]", d), 32'(rd_en[d]), hist[1].act);
      chk($sformatf("rd_addr[%0d]", d), 32'(rd_addr[d]), exp_addr);
      chk($sformatf("pixel[%0d]", d), 32'(pix[d]), (r.act != 0) ? (r.addr & 32'hFFF) : 0);
      chk($sformatf("hsync[%0d]", d), 32'(hsync[d]), r.hs);
      chk($sformatf("vsync[%0d]", d), 32'(vsync[d]), r.vs);
      chk($sformatf("active[%0d]", d), 32'(act[d]), r.act);
      chk($sformatf("frame_start[%0d]", d), 32'(fs[d]), r.fs);
      if (r.act != 0) begin
        chk($sformatf("x[%0d]", d), 32'(x[d]), r.h);
        chk($sformatf("y[%0d]", d), 32'(y[d]), r.v);
      end
    end
  endtask

  task automatic step(input bit e);
    rise(e);
    fall();
  endtask

  // Async reset pulse between edges; outputs must be at reset values before the next edge.
  task automatic reset_pulse(input bit e);
    rise(e);
    #1 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rd_en[%0d]", d), 32'(rd_en[d]), 0);
      chk($sformatf("rst_rd_addr[%0d]", d), 32'(rd_addr[d]), 0);
      chk($sformatf("rst_pixel[%0d]", d), 32'(pix[d]), 0);
      chk($sformatf("rst_hsync[%0d]", d), 32'(hsync[d]), 1);
      chk($sformatf("rst_vsync[%0d]", d), 32'(vsync[d]), 1);
      chk($sformatf("rst_active[%0d]", d), 32'(act[d]), 0);
      chk($sformatf("rst_fs[%0d]", d), 32'(fs[d]), 0);
      chk($sformatf("rst_xy[%0d]", d), 32'({x[d], y[d]}), 0);
    end
    rstn     = 1'b1;
    pos      = 0;
    exp_addr = 0;
    for (int i = 0; i < 16; i++) hist[i] = decode(0, 1'b0);
    hist[0] = decode(0, e);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        mem_en[d][i]   = 1'b0;
        mem_addr[d][i] = 0;
      end
    fall();
  endtask

  // After a restart in cycle e: fresh read of address 0 at e+1, frame_start at e+RD_LAT+2.
  task automatic check_restart(input string tag);
    for (int j = 1; j <= 9; j++) begin
      step(1'b1);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("%s_fs[%0d]_j%0d", tag, d, j), 32'(fs[d]), (j == lat_of(d) + 2) ? 1 : 0);
        if (j == 1) begin
          chk($sformatf("%s_first_rd_en[%0d]", tag, d), 32'(rd_en[d]), 1);
          chk($sformatf("%s_first_addr[%0d]", tag, d), 32'(rd_addr[d]), 0);
        end
      end
    end
    $display("restart %s: frame_start checked for latencies %0d and %0d", tag, LAT_A, LAT_B);
  endtask

  initial begin
    int vi;
    int guard;
    //            k  rd_en addr act hs vs pix fs   (instance with RD_LAT=2)
    tbl[0]  = '{  0, 0,  0,  0, 1, 1,  0, 0};
    tbl[1]  = '{  1, 1,  0,  0, 1, 1,  0, 0};
    tbl[2]  = '{  4, 1,  3,  1, 1, 1,  0, 1};
    tbl[3]  = '{  5, 1,  4,  1, 1, 1,  1, 0};
    tbl[4]  = '{  9, 0,  7,  1, 1, 1,  5, 0};
    tbl[5]  = '{ 12, 0,  7,  0, 1, 1,  0, 0};
    tbl[6]  = '{ 14, 0,  7,  0, 0, 1,  0, 0};
    tbl[7]  = '{ 16, 1,  8,  0, 0, 1,  0, 0};
    tbl[8]  = '{ 17, 1,  9,  0, 1, 1,  0, 0};
    tbl[9]  = '{ 19, 1, 11,  1, 1, 1,  8, 0};
    tbl[10] = '{ 56, 0, 31,  1, 1, 1, 31, 0};
    tbl[11] = '{ 57, 0, 31,  0, 1, 1,  0, 0};
    tbl[12] = '{ 78, 0, 31,  0, 1, 1,  0, 0};
    tbl[13] = '{ 79, 0, 31,  0, 1, 0,  0, 0};
    tbl[14] = '{108, 0, 31,  0, 1, 0,  0, 0};
    tbl[15] = '{109, 0, 31,  0, 1, 1,  0, 0};
    tbl[16] = '{121, 1,  0,  0, 0, 1,  0, 0};
    tbl[17] = '{124, 1,  3,  1, 1, 1,  0, 1};

    for (int i = 0; i < 16; i++) hist[i] = decode(0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      rd_data[d] = 12'h000;
      for (int i = 0; i < 16; i++) begin
        mem_en[d][i]   = 1'b0;
        mem_addr[d][i] = 0;
      end
    end

    // Reset held, then released mid-cycle with the raster disabled for 50 cycles.
    repeat (3) step(1'b0);
    rise(1'b0);
    rstn = 1'b1;
    fall();
    repeat (50) step(1'b0);
    $display("idle: 50 disabled cycles after reset checked");

    // Directed vectors from the first enabled cycle.
    vi = 0;
    for (int k = 0; k <= 125; k++) begin
      step(1'b1);
      while (vi < 18 && tbl[vi].k == k) begin
        chk($sformatf("vec%0d_rd_en", vi), 32'(rd_en[0]), tbl[vi].rd_en);
        chk($sformatf("vec%0d_rd_addr", vi), 32'(rd_addr[0]), tbl[vi].rd_addr);
        chk($sformatf("vec%0d_active", vi), 32'(act[0]), tbl[vi].act);
        chk($sformatf("vec%0d_hsync", vi), 32'(hsync[0]), tbl[vi].hs);
        chk($sformatf("vec%0d_vsync", vi), 32'(vsync[0]), tbl[vi].vs);
        chk($sformatf("vec%0d_pixel", vi), 32'(pix[0]), tbl[vi].pix);
        chk($sformatf("vec%0d_fs", vi), 32'(fs[0]), tbl[vi].fs);
        $display("vec %0d k=%0d rd_en=%0d addr=%0d act=%0d hs=%0d vs=%0d pix=%0d fs=%0d",
                 vi, k, rd_en[0], rd_addr[0], act[0], hsync[0], vsync[0], pix[0], fs[0]);
        vi++;
      end
    end
    repeat (2 * FRAME) step(1'b1);
    $display("frames: two further frames checked against the model");

    // Enable drop at line 2, column 5.
    guard = 0;
    while (pos != 34 && guard < 4 * FRAME) begin
      step(1'b1);
      guard++;
    end
    chk("seek_line2_timeout", 32'(guard < 4 * FRAME), 1);
    step(1'b0);
    step(1'b0);
    for (int d = 0; d < 2; d++) chk($sformatf("drop_rd_en[%0d]", d), 32'(rd_en[d]), 0);
    repeat (6) step(1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("drop_active[%0d]", d), 32'(act[d]), 0);
      chk($sformatf("drop_pixel[%0d]", d), 32'(pix[d]), 0);
    end
    $display("enable drop at (5,2): outputs drained");
    step(1'b1);
    check_restart("enable");

    // Async reset while a visible pixel is on the outputs.
    guard = 0;
    while (!(act[0] === 1'b1 && y[0] == 10'd1) && guard < 4 * FRAME) begin
      step(1'b1);
      guard++;
    end
    chk("seek_active_timeout", 32'(guard < 4 * FRAME), 1);
    reset_pulse(1'b1);
    check_restart("reset");

    // Randomized enable activity with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        reset_pulse(1'b1);
      end else if (r < 10) begin
        repeat ($urandom_range(1, 20)) step(1'b0);
      end else begin
        step(1'b1);
      end
    end
    $display("random: 3000 randomized cycles checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
